// File: rtl/ptmch_pkg.sv
// ---------------------------------------------------------------------------
// ptmch_pkg
// Shared constants for the pattern-match trigger command generator:
//   - SPI NAND opcode constants driven by the stimulus side
//   - FSM state encodings for ptmch_spi_cmdgen
//   - frame lengths (plain command frame, command frame plus read byte)
//   - helper that classifies status-read opcodes (used by the optional
//     read-back path enabled with PTMCH_CMDGEN_MISO_EN)
// ---------------------------------------------------------------------------
package ptmch_pkg;

  // SPI NAND opcodes
  localparam logic [7:0] p_program_excute   = 8'h10;
  localparam logic [7:0] p_readstatus1      = 8'h0f;
  localparam logic [7:0] p_readstatus2      = 8'h05;
  localparam logic [7:0] p_128kb_blockerase = 8'hd8;
  localparam logic [7:0] p_pagedata_read    = 8'h13;
  localparam logic [7:0] p_writestatus1     = 8'h1f;
  localparam logic [7:0] p_writestatus2     = 8'h01;

  // Frame lengths in SPI bits
  localparam int FRAME_LEN_CMD = 32;
  localparam int FRAME_LEN_RD  = 40;

  // Command generator FSM states
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_SETUP = 3'd1;
  localparam state_t ST_SHIFT = 3'd2;
  localparam state_t ST_HOLD  = 3'd3;
  localparam state_t ST_GAP   = 3'd4;

  // Status reads are the only opcodes that clock a response byte back
  function automatic logic is_status_read(input logic [7:0] op);
    return (op == p_readstatus1) || (op == p_readstatus2);
  endfunction

endpackage

// File: rtl/ptmch_sclk_gen.sv
// ---------------------------------------------------------------------------
// ptmch_sclk_gen
// SPI serial clock divider. While en is high, sclk toggles every CLK_DIV
// CLK160M cycles, starting with a rising edge on the first enabled cycle.
// While en is low, sclk is held low and the divider restarts.
//
// Ports:
//   CLK160M   in   sole clock
//   RESET     in   synchronous, active-high reset
//   en        in   run the divider
//   sclk      out  registered serial clock, idles low
//   rise_stb  out  high in the cycle whose closing edge raises sclk
//   fall_stb  out  high in the cycle whose closing edge lowers sclk
//
// The strobes announce the upcoming edge so the parent can update its own
// registers (MOSI shift, MISO sample) on exactly the same CLK160M edge.
// ---------------------------------------------------------------------------
module ptmch_sclk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic CLK160M,
  input  logic RESET,
  input  logic en,
  output logic sclk,
  output logic rise_stb,
  output logic fall_stb
);

  logic [7:0] div_cnt_reg;
  logic       sclk_reg;
  logic       tick;

  assign tick     = en && (div_cnt_reg == 8'd0);
  assign rise_stb = tick && !sclk_reg;
  assign fall_stb = tick && sclk_reg;
  assign sclk     = sclk_reg;

  always_ff @(posedge CLK160M) begin
    if (RESET) begin
      div_cnt_reg <= 8'd0;
      sclk_reg    <= 1'b0;
    end else if (!en) begin
      div_cnt_reg <= 8'd0;
      sclk_reg    <= 1'b0;
    end else if (tick) begin
      sclk_reg    <= !sclk_reg;
      div_cnt_reg <= 8'(CLK_DIV - 1);
    end else begin
      div_cnt_reg <= div_cnt_reg - 8'd1;
    end
  end

endmodule

// File: rtl/ptmch_spi_cmdgen.sv
// ---------------------------------------------------------------------------
// ptmch_spi_cmdgen
// SPI mode-0 master that serializes one {opcode, 24-bit address} frame per
// accepted request, MSB first, for the flash bus and the trigger matcher
// loopback.
//
// Parameters (CLK160M cycles):
//   CLK_DIV   SPI_CLK half period (2..255)
//   CS_SETUP  SPI_CS fall to first SPI_CLK rise (1..255)
//   CS_HOLD   end of last bit to SPI_CS rise (1..255)
//   CS_IDLE   minimum SPI_CS high time between frames (1..255)
//
// Ports:
//   CLK160M     in   sole clock
//   RESET       in   synchronous, active-high reset
//   CMD_VALID   in   request qualifier
//   CMD_READY   out  block can accept a frame
//   CMD_OPCODE  in   8-bit opcode
//   CMD_ADDR    in   24-bit address
//   CMD_DONE    out  one-cycle pulse at frame completion (with SPI_CS rise)
//   SPI_CS      out  chip select, active low
//   SPI_CLK     out  serial clock, idles low
//   SPI_MOSI    out  serial data out
//   SPI_MISO    in   serial data in     (only with PTMCH_CMDGEN_MISO_EN)
//   RD_DATA     out  captured read byte (only with PTMCH_CMDGEN_MISO_EN)
//
// Build option PTMCH_CMDGEN_MISO_EN: status-read opcodes (0x0f, 0x05) run
// 40 bits, MOSI is 0 for bits 32..39, and MISO is sampled on those rises.
// ---------------------------------------------------------------------------
module ptmch_spi_cmdgen
  import ptmch_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 4,
  parameter int CS_HOLD  = 4,
  parameter int CS_IDLE  = 8
) (
  input  logic        CLK160M,
  input  logic        RESET,
  input  logic        CMD_VALID,
  output logic        CMD_READY,
  input  logic [7:0]  CMD_OPCODE,
  input  logic [23:0] CMD_ADDR,
  output logic        CMD_DONE,
  output logic        SPI_CS,
  output logic        SPI_CLK,
  output logic        SPI_MOSI
`ifdef PTMCH_CMDGEN_MISO_EN
  ,
  input  logic        SPI_MISO,
  output logic [7:0]  RD_DATA
`endif
);

  state_t      state_reg;
  logic [7:0]  cnt_reg;       // phase length counter (setup/tail/hold/gap)
  logic [5:0]  bit_cnt_reg;   // SPI_CLK rises seen in this frame
  logic [31:0] shreg_reg;
  logic        tail_reg;      // last fall done, low phase of final bit running
  logic        cs_reg;
  logic        mosi_reg;
  logic        ready_reg;
  logic        done_reg;

  logic        sclk_en;
  logic        sclk;
  logic        rise_stb;
  logic        fall_stb;
  logic [5:0]  frame_bits;

`ifdef PTMCH_CMDGEN_MISO_EN
  logic        long_frame_reg;
  logic [7:0]  rx_reg;
  logic [7:0]  rd_data_reg;

  assign frame_bits = long_frame_reg ? 6'(FRAME_LEN_RD) : 6'(FRAME_LEN_CMD);
  assign RD_DATA    = rd_data_reg;
`else
  assign frame_bits = 6'(FRAME_LEN_CMD);
`endif

  // The divider starts during the final SETUP cycle so the first rise lands
  // exactly CS_SETUP cycles after SPI_CS falls. It stops once the last fall
  // has been issued; the remaining low phase is timed by cnt_reg.
  assign sclk_en = ((state_reg == ST_SETUP) && (cnt_reg == 8'd0)) ||
                   ((state_reg == ST_SHIFT) && !tail_reg);

  ptmch_sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_gen (
    .CLK160M  (CLK160M),
    .RESET    (RESET),
    .en       (sclk_en),
    .sclk     (sclk),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb)
  );

  assign SPI_CS    = cs_reg;
  assign SPI_CLK   = sclk;
  assign SPI_MOSI  = mosi_reg;
  assign CMD_READY = ready_reg;
  assign CMD_DONE  = done_reg;

  always_ff @(posedge CLK160M) begin
    if (RESET) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= 8'd0;
      bit_cnt_reg <= 6'd0;
      shreg_reg   <= 32'd0;
      tail_reg    <= 1'b0;
      cs_reg      <= 1'b1;
      mosi_reg    <= 1'b0;
      ready_reg   <= 1'b0;
      done_reg    <= 1'b0;
`ifdef PTMCH_CMDGEN_MISO_EN
      long_frame_reg <= 1'b0;
`endif
    end else begin
      done_reg <= 1'b0;

      if (rise_stb) begin
        bit_cnt_reg <= bit_cnt_reg + 6'd1;
      end

      case (state_reg)
        ST_IDLE: begin
          if (ready_reg && CMD_VALID) begin
            shreg_reg   <= {CMD_OPCODE, CMD_ADDR};
            mosi_reg    <= CMD_OPCODE[7];
            cs_reg      <= 1'b0;
            ready_reg   <= 1'b0;
            bit_cnt_reg <= 6'd0;
            tail_reg    <= 1'b0;
            cnt_reg     <= 8'(CS_SETUP - 1);
            state_reg   <= ST_SETUP;
`ifdef PTMCH_CMDGEN_MISO_EN
            long_frame_reg <= is_status_read(CMD_OPCODE);
`endif
          end else begin
            // Also covers the first cycle out of reset
            ready_reg <= 1'b1;
          end
        end

        ST_SETUP: begin
          if (cnt_reg == 8'd0) begin
            state_reg <= ST_SHIFT;
          end else begin
            cnt_reg <= cnt_reg - 8'd1;
          end
        end

        ST_SHIFT: begin
          // The final bit's low phase still belongs to SHIFT so that
          // CS_HOLD is measured from the end of the full 2*CLK_DIV bit slot.
          if (tail_reg) begin
            if (cnt_reg == 8'd0) begin
              cnt_reg   <= 8'(CS_HOLD - 1);
              state_reg <= ST_HOLD;
            end else begin
              cnt_reg <= cnt_reg - 8'd1;
            end
          end else if (fall_stb) begin
            if (bit_cnt_reg == frame_bits) begin
              tail_reg <= 1'b1;
              cnt_reg  <= 8'(CLK_DIV - 1);
            end else begin
              // Zero fill provides MOSI=0 for any bits past the command word
              shreg_reg <= {shreg_reg[30:0], 1'b0};
              mosi_reg  <= shreg_reg[30];
            end
          end
        end

        ST_HOLD: begin
          if (cnt_reg == 8'd0) begin
            cs_reg    <= 1'b1;
            mosi_reg  <= 1'b0;
            done_reg  <= 1'b1;
            cnt_reg   <= 8'(CS_IDLE - 1);
            state_reg <= ST_GAP;
          end else begin
            cnt_reg <= cnt_reg - 8'd1;
          end
        end

        ST_GAP: begin
          if (cnt_reg == 8'd0) begin
            ready_reg <= 1'b1;
            state_reg <= ST_IDLE;
          end else begin
            cnt_reg <= cnt_reg - 8'd1;
          end
        end

        default: begin
          cs_reg    <= 1'b1;
          mosi_reg  <= 1'b0;
          ready_reg <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef PTMCH_CMDGEN_MISO_EN
  // Response byte: sampled on the rises of bits 32..39 (bit_cnt_reg holds
  // the index of the bit whose rise is happening), published with CMD_DONE.
  always_ff @(posedge CLK160M) begin
    if (RESET) begin
      rx_reg      <= 8'd0;
      rd_data_reg <= 8'd0;
    end else begin
      if (rise_stb && (state_reg == ST_SHIFT) && long_frame_reg &&
          (bit_cnt_reg >= 6'(FRAME_LEN_CMD))) begin
        rx_reg <= {rx_reg[6:0], SPI_MISO};
      end
      if ((state_reg == ST_HOLD) && (cnt_reg == 8'd0) && long_frame_reg) begin
        rd_data_reg <= rx_reg;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ptmch_spi_cmdgen.sv
`timescale 1ns/1ps
module tb_ptmch_spi_cmdgen;

  localparam int CLK_DIV  = 4;
  localparam int CS_SETUP = 4;
  localparam int CS_HOLD  = 4;
  localparam int CS_IDLE  = 8;
  localparam int LOW32    = CS_SETUP + 64 * CLK_DIV + CS_HOLD;  // 264
  localparam int LOW40    = CS_SETUP + 80 * CLK_DIV + CS_HOLD;  // 328
  localparam int NV       = 9;

  logic        CLK160M = 1'b0;
  logic        RESET = 1'b1;
  logic        CMD_VALID = 1'b0;
  logic [7:0]  CMD_OPCODE = 8'h00;
  logic [23:0] CMD_ADDR = 24'h0;
  logic        CMD_READY, CMD_DONE, SPI_CS, SPI_CLK, SPI_MOSI;
`ifdef PTMCH_CMDGEN_MISO_EN
  logic        SPI_MISO;
  logic [7:0]  RD_DATA;
`endif

  always #3 CLK160M = ~CLK160M;

  ptmch_spi_cmdgen #(
    .CLK_DIV  (CLK_DIV),
    .CS_SETUP (CS_SETUP),
    .CS_HOLD  (CS_HOLD),
    .CS_IDLE  (CS_IDLE)
  ) dut (
    .CLK160M    (CLK160M),
    .RESET      (RESET),
    .CMD_VALID  (CMD_VALID),
    .CMD_READY  (CMD_READY),
    .CMD_OPCODE (CMD_OPCODE),
    .CMD_ADDR   (CMD_ADDR),
    .CMD_DONE   (CMD_DONE),
    .SPI_CS     (SPI_CS),
    .SPI_CLK    (SPI_CLK),
    .SPI_MOSI   (SPI_MOSI)
`ifdef PTMCH_CMDGEN_MISO_EN
    ,
    .SPI_MISO   (SPI_MISO),
    .RD_DATA    (RD_DATA)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- bus monitor (samples on the falling edge) -------------
  typedef struct {
    logic [39:0] bits;
    int          rises;
    int          cs_low;
    int          gap;
  } frame_t;

  frame_t      frames_q[$];
  logic [39:0] cur_bits = '0;
  int          cur_rises = 0;
  int          cur_cs_low = 0;
  int          cur_gap = 0;
  int          last_gap = 0;
  int          done_cnt = 0;
  logic [7:0]  rd_at_done = 8'h00;
  logic        prev_cs = 1'b1;
  logic        prev_sclk = 1'b0;

  always @(negedge CLK160M) begin
    if (SPI_CS === 1'b0 && prev_cs === 1'b1) begin
      cur_bits = '0; cur_rises = 0; cur_cs_low = 0; last_gap = cur_gap;
    end
    if (SPI_CS === 1'b0) begin
      cur_cs_low++;
      if (SPI_CLK === 1'b1 && prev_sclk === 1'b0) begin
        cur_bits = {cur_bits[38:0], SPI_MOSI};
        cur_rises++;
      end
    end
    if (SPI_CS === 1'b1 && prev_cs === 1'b0) begin
      frames_q.push_back('{cur_bits, cur_rises, cur_cs_low, last_gap});
      cur_gap = 0;
    end
    if (SPI_CS === 1'b1) cur_gap++;
    if (CMD_DONE === 1'b1) begin
      done_cnt++;
`ifdef PTMCH_CMDGEN_MISO_EN
      rd_at_done = RD_DATA;
`endif
    end
    prev_cs = SPI_CS;
    prev_sclk = SPI_CLK;
  end

`ifdef PTMCH_CMDGEN_MISO_EN
  // Flash model: answers 0xa5 MSB first during bits 32..39
  logic [7:0] miso_byte = 8'ha5;
  always @* begin
    if (cur_rises >= 32 && cur_rises < 40) SPI_MISO = miso_byte[39 - cur_rises];
    else SPI_MISO = 1'b0;
  end
`endif

  // Trigger matcher model: program-execute inside the address window
  logic [23:0] win_lo = 24'h000000;
  logic [23:0] win_hi = 24'h0001ff;
  function automatic logic pe_trigger(input logic [31:0] f);
    return (f[31:24] == 8'h10) && (f[23:0] >= win_lo) && (f[23:0] <= win_hi);
  endfunction

  // ---------------- helpers ----------------------------------------------
  task automatic tick();
    @(negedge CLK160M);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    int t = 0;
    while (CMD_READY !== 1'b1 && t < 1000) begin tick(); t++; end
    check("ready_wait", CMD_READY, 1);
  endtask

  task automatic send(input logic [7:0] op, input logic [23:0] addr);
    wait_ready();
    CMD_VALID = 1'b1; CMD_OPCODE = op; CMD_ADDR = addr;
    tick();
    CMD_VALID = 1'b0; CMD_OPCODE = ~op; CMD_ADDR = ~addr;
  endtask

  task automatic wait_frames(input int n);
    int t = 0;
    while (frames_q.size() < n && t < 2000) begin tick(); t++; end
    check("frame_wait", frames_q.size(), n);
  endtask

  function automatic logic [31:0] cmd_word(input frame_t f);
    return (f.rises == 40) ? f.bits[39:8] : f.bits[31:0];
  endfunction

  // ---------------- vector table ----------------------------------------
  typedef struct {
    logic [7:0]  op;
    logic [23:0] addr;
    logic [39:0] exp_bits;
    int          exp_rises;
    int          exp_low;
    logic        exp_trig;
  } vec_t;

  vec_t   vecs[NV];
  frame_t f;
  frame_t f2;
  int     d0;

  initial begin : main
    vecs[0] = '{8'h13, 24'h001234, {8'h00, 32'h13001234}, 32, LOW32, 1'b0};
    vecs[1] = '{8'hd8, 24'hffffff, {8'h00, 32'hd8ffffff}, 32, LOW32, 1'b0};
    vecs[2] = '{8'h10, 24'h000000, {8'h00, 32'h10000000}, 32, LOW32, 1'b1};
    vecs[3] = '{8'h10, 24'h000100, {8'h00, 32'h10000100}, 32, LOW32, 1'b1};
    vecs[4] = '{8'h10, 24'h000200, {8'h00, 32'h10000200}, 32, LOW32, 1'b0};
`ifdef PTMCH_CMDGEN_MISO_EN
    vecs[5] = '{8'h0f, 24'h123456, {32'h0f123456, 8'h00}, 40, LOW40, 1'b0};
    vecs[6] = '{8'h05, 24'habcdef, {32'h05abcdef, 8'h00}, 40, LOW40, 1'b0};
`else
    vecs[5] = '{8'h0f, 24'h123456, {8'h00, 32'h0f123456}, 32, LOW32, 1'b0};
    vecs[6] = '{8'h05, 24'habcdef, {8'h00, 32'h05abcdef}, 32, LOW32, 1'b0};
`endif
    vecs[7] = '{8'h1f, 24'h00a0a0, {8'h00, 32'h1f00a0a0}, 32, LOW32, 1'b0};
    vecs[8] = '{8'h01, 24'h800001, {8'h00, 32'h01800001}, 32, LOW32, 1'b0};

    // Reset state
    repeat (3) tick();
    check("rst_cs", SPI_CS, 1);
    check("rst_sclk", SPI_CLK, 0);
    check("rst_mosi", SPI_MOSI, 0);
    check("rst_ready", CMD_READY, 0);
    check("rst_done", CMD_DONE, 0);
`ifdef PTMCH_CMDGEN_MISO_EN
    check("rst_rd_data", RD_DATA, 8'h00);
`endif
    RESET = 1'b0;
    tick();
    check("ready_after_reset", CMD_READY, 1);

    // Table-driven single frames
    for (int i = 0; i < NV; i++) begin
      d0 = done_cnt;
      send(vecs[i].op, vecs[i].addr);
      wait_frames(1);
      repeat (2) tick();
      f = '{40'h0, 0, 0, 0};
      if (frames_q.size() > 0) f = frames_q.pop_front();
      $display("vec %0d op=%h addr=%h bits=%h rises=%0d cs_low=%0d", i,
               vecs[i].op, vecs[i].addr, f.bits, f.rises, f.cs_low);
      if (vecs[i].exp_rises == 40) check("frame_bits", f.bits, vecs[i].exp_bits);
      else check("frame_bits", f.bits[31:0], vecs[i].exp_bits[31:0]);
      check("rise_count", f.rises, vecs[i].exp_rises);
      check("cs_low_cycles", f.cs_low, vecs[i].exp_low);
      check("done_pulses", done_cnt - d0, 1);
      check("pe_trigger", pe_trigger(cmd_word(f)), vecs[i].exp_trig);
`ifdef PTMCH_CMDGEN_MISO_EN
      if (vecs[i].exp_rises == 40) check("rd_data_at_done", rd_at_done, 8'ha5);
`endif
    end

    // Back-to-back with VALID held and the opcode changed mid-frame
    wait_ready();
    frames_q.delete();
    d0 = done_cnt;
    CMD_VALID = 1'b1; CMD_OPCODE = 8'hd8; CMD_ADDR = 24'hffffff;
    tick();
    for (int t = 0; t < 500 && cur_rises < 5; t++) tick();
    CMD_OPCODE = 8'h10; CMD_ADDR = 24'h000000;
    wait_frames(1);
    for (int t = 0; t < 50 && SPI_CS !== 1'b0; t++) tick();
    check("b2b_second_accept", SPI_CS, 0);
    CMD_VALID = 1'b0; CMD_OPCODE = 8'h55; CMD_ADDR = 24'h555555;
    wait_frames(2);
    repeat (2) tick();
    f = '{40'h0, 0, 0, 0};
    f2 = '{40'h0, 0, 0, 0};
    if (frames_q.size() > 0) f = frames_q.pop_front();
    if (frames_q.size() > 0) f2 = frames_q.pop_front();
    $display("b2b frame0=%h frame1=%h gap=%0d", f.bits[31:0], f2.bits[31:0], f2.gap);
    check("b2b_frame0", f.bits[31:0], 32'hd8ffffff);
    check("b2b_frame1", f2.bits[31:0], 32'h10000000);
    check("b2b_cs_gap", f2.gap, CS_IDLE + 1);
    check("b2b_done_pulses", done_cnt - d0, 2);
    repeat (400) tick();
    check("b2b_no_extra_frame", frames_q.size(), 0);

    // Reset at the 10th SPI_CLK rise
    d0 = done_cnt;
    send(8'h13, 24'h001234);
    for (int t = 0; t < 500 && cur_rises < 10; t++) tick();
    check("rise10_wait", cur_rises, 10);
    RESET = 1'b1;
    tick();
    $display("reset mid-frame cs=%b sclk=%b mosi=%b", SPI_CS, SPI_CLK, SPI_MOSI);
    check("midrst_cs", SPI_CS, 1);
    check("midrst_sclk", SPI_CLK, 0);
    check("midrst_mosi", SPI_MOSI, 0);
    check("midrst_ready", CMD_READY, 0);
    repeat (3) tick();
    RESET = 1'b0;
    repeat (20) tick();
    check("midrst_no_done", done_cnt - d0, 0);
    frames_q.delete();
    send(8'h1f, 24'h00a0a0);
    wait_frames(1);
    repeat (2) tick();
    f = '{40'h0, 0, 0, 0};
    if (frames_q.size() > 0) f = frames_q.pop_front();
    $display("post-reset frame=%h rises=%0d cs_low=%0d", f.bits[31:0], f.rises, f.cs_low);
    check("postrst_frame", f.bits[31:0], 32'h1f00a0a0);
    check("postrst_rises", f.rises, 32);
    check("postrst_cs_low", f.cs_low, LOW32);
    check("postrst_done", done_cnt - d0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, expected completion");
    $fatal(1);
  end

endmodule
